// File: rtl/phi2_pkg.sv
// Shared definitions for the PHI2 phase generator.
//   phi2_state_t : lock state machine encoding
//   DEF_*        : default timing constants (C8M cycles / PHI2 cycles)
//   sat_inc()    : increment that holds at a ceiling value
package phi2_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } phi2_state_t;

    localparam int DEF_MIN_PER     = 6;
    localparam int DEF_MAX_PER     = 10;
    localparam int DEF_TIMEOUT     = 14;
    localparam int DEF_LOCK_CYCLES = 4;
    localparam int DEF_REF_DIV     = 7;

    // Accepted PHI2 high time window when the duty check is built in.
    localparam int DUTY_HI_MIN = 3;
    localparam int DUTY_HI_MAX = 5;

    function automatic int unsigned sat_inc(input int unsigned val,
                                            input int unsigned max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/phi2_edge_sync.sv
// PHI2 synchroniser and edge strobe generator.
// Ports:
//   i_clk      : C8M clock
//   i_rst      : asynchronous active-high reset
//   i_phi2     : raw PHI2, asynchronous to i_clk
//   o_phi2s    : PHI2 delayed by SYNC_STAGES clock edges
//   o_rise     : registered one-cycle strobe, cycle after o_phi2s rises
//   o_fall     : registered one-cycle strobe, cycle after o_phi2s falls
//   o_fall_pre : combinational fall detect, one cycle ahead of o_fall; lets
//                the parent register a pulse that lines up with o_fall
module phi2_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_phi2,
    output logic o_phi2s,
    output logic o_rise,
    output logic o_fall,
    output logic o_fall_pre
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_phi2s;
    logic                   w_rise_pre;
    logic                   w_fall_pre;

    assign w_phi2s    = r_sync[SYNC_STAGES-1];
    assign w_rise_pre = w_phi2s & ~r_prev;
    assign w_fall_pre = ~w_phi2s & r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_phi2};
            r_prev <= w_phi2s;
            r_rise <= w_rise_pre;
            r_fall <= w_fall_pre;
        end
    end

    assign o_phi2s    = w_phi2s;
    assign o_rise     = r_rise;
    assign o_fall     = r_fall;
    assign o_fall_pre = w_fall_pre;

endmodule

// File: rtl/phi2_phase_gen.sv
// PHI2 bus-timing front end for the REU: synchronises PHI2 into C8M, gives
// edge strobes, a phase counter, a rise-to-rise period measurement, PHI2 lock
// tracking and the SDRAM refresh tick.
// Build option: PHI2_DUTY_CHECK_EN adds a high-time check to the "good rise"
// rule and exposes the measured high time on o_hi_time.
// Ports:
//   i_c8m        : system clock
//   i_reset      : asynchronous active-high reset
//   i_phi2       : raw 6502 PHI2
//   o_phi2s      : synchronised PHI2
//   o_phi2_rise  : one-cycle strobe on PHI2S rising edge
//   o_phi2_fall  : one-cycle strobe on PHI2S falling edge
//   o_phase      : C8M cycles since the latest PHI2S edge (saturating)
//   o_period     : last rise-to-rise period in C8M cycles
//   o_locked     : PHI2 stable and in range
//   o_lost       : one-cycle strobe on timeout / bad period while tracking
//   o_hi_time    : (PHI2_DUTY_CHECK_EN only) last PHI2S high time
//   o_ref_tick   : one-cycle SDRAM refresh request
//
// state    | meaning
// ---------+-------------------------------------------------------------
// UNLOCKED | no PHI2 seen (or timed out); waiting for a first rise
// ACQUIRE  | counting consecutive in-range periods towards lock
// LOCKED   | PHI2 trusted; refresh aligned to PHI2 falling edge
module phi2_phase_gen
    import phi2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4,
    parameter int MIN_PER     = DEF_MIN_PER,
    parameter int MAX_PER     = DEF_MAX_PER,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
    parameter int REF_DIV     = DEF_REF_DIV
) (
    input  logic             i_c8m,
    input  logic             i_reset,
    input  logic             i_phi2,
    output logic             o_phi2s,
    output logic             o_phi2_rise,
    output logic             o_phi2_fall,
    output logic [CNT_W-1:0] o_phase,
    output logic [CNT_W-1:0] o_period,
    output logic             o_locked,
    output logic             o_lost,
`ifdef PHI2_DUTY_CHECK_EN
    output logic [CNT_W-1:0] o_hi_time,
`endif
    output logic             o_ref_tick
);

    localparam int unsigned CNT_MAX   = (32'd1 << CNT_W) - 32'd1;
    localparam int unsigned FREE_LAST = REF_DIV * 8 - 1;
    localparam int          FREE_W    = $clog2(REF_DIV * 8);

    phi2_state_t      r_state;
    phi2_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_good_cnt;
    logic [CNT_W-1:0] w_good_nxt;
    logic             w_lost_nxt;

    logic [CNT_W-1:0] r_phase;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_per_cnt;
    logic [CNT_W-1:0] r_ref_cnt;
    logic [FREE_W-1:0] r_free_cnt;
    logic             r_locked;
    logic             r_lost;
    logic             r_ref_tick;
    logic             r_ref_pend;

    logic             w_phi2s;
    logic             w_rise;
    logic             w_fall;
    logic             w_fall_pre;
    logic [CNT_W:0]   w_per_meas;
    logic             w_per_ok;
    logic             w_duty_ok;
    logic             w_good;
    logic             w_timeout;

    phi2_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .i_clk      (i_c8m),
        .i_rst      (i_reset),
        .i_phi2     (i_phi2),
        .o_phi2s    (w_phi2s),
        .o_rise     (w_rise),
        .o_fall     (w_fall),
        .o_fall_pre (w_fall_pre)
    );

    // One bit wider than the counter so a saturated PerCnt never looks
    // like a short period.
    assign w_per_meas = {1'b0, r_per_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_per_ok   = (w_per_meas >= (CNT_W+1)'(MIN_PER)) &&
                        (w_per_meas <= (CNT_W+1)'(MAX_PER));
    assign w_timeout  = (r_per_cnt >= CNT_W'(TIMEOUT));

`ifdef PHI2_DUTY_CHECK_EN
    logic [CNT_W-1:0] r_hi_cnt;
    logic [CNT_W-1:0] r_hi_time;

    always_ff @(posedge i_c8m or posedge i_reset) begin
        if (i_reset) begin
            r_hi_cnt  <= '0;
            r_hi_time <= '0;
        end else begin
            if (w_rise) begin
                r_hi_cnt <= '0;
            end else begin
                r_hi_cnt <= CNT_W'(sat_inc(32'(r_hi_cnt), CNT_MAX));
            end
            if (w_fall) begin
                r_hi_time <= CNT_W'(sat_inc(32'(r_hi_cnt), CNT_MAX));
            end
        end
    end

    // The rise being judged closes a period whose high time was captured
    // at the fall inside it.
    assign w_duty_ok = (r_hi_time >= CNT_W'(DUTY_HI_MIN)) &&
                       (r_hi_time <= CNT_W'(DUTY_HI_MAX));
    assign o_hi_time = r_hi_time;
`else
    assign w_duty_ok = 1'b1;
`endif

    assign w_good = w_per_ok & w_duty_ok;

    // A rise takes priority over a timeout in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        w_lost_nxt  = 1'b0;
        case (r_state)
            UNLOCKED: begin
                if (w_rise) begin
                    w_state_nxt = ACQUIRE;
                    w_good_nxt  = '0;
                end
            end
            ACQUIRE: begin
                if (w_rise) begin
                    if (w_good) begin
                        if (r_good_cnt == CNT_W'(LOCK_CYCLES - 1)) begin
                            w_state_nxt = LOCKED;
                            w_good_nxt  = '0;
                        end else begin
                            w_good_nxt = r_good_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_good_nxt = '0;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = UNLOCKED;
                    w_good_nxt  = '0;
                    w_lost_nxt  = 1'b1;
                end
            end
            LOCKED: begin
                if (w_rise) begin
                    if (!w_good) begin
                        w_state_nxt = ACQUIRE;
                        w_good_nxt  = '0;
                        w_lost_nxt  = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = UNLOCKED;
                    w_good_nxt  = '0;
                    w_lost_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = UNLOCKED;
                w_good_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge i_c8m or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= UNLOCKED;
            r_good_cnt <= '0;
            r_lost     <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_cnt <= w_good_nxt;
            r_lost     <= w_lost_nxt;
            r_locked   <= (r_state == LOCKED);
        end
    end

    always_ff @(posedge i_c8m or posedge i_reset) begin
        if (i_reset) begin
            r_phase   <= '0;
            r_period  <= '0;
            r_per_cnt <= '0;
        end else begin
            if (w_rise || w_fall) begin
                r_phase <= '0;
            end else begin
                r_phase <= CNT_W'(sat_inc(32'(r_phase), CNT_MAX));
            end
            if (w_rise) begin
                r_period  <= CNT_W'(sat_inc(32'(r_per_cnt), CNT_MAX));
                r_per_cnt <= '0;
            end else begin
                r_per_cnt <= CNT_W'(sat_inc(32'(r_per_cnt), CNT_MAX));
            end
        end
    end

    // Refresh: PHI2-aligned while LOCKED (tick on the fall after the
    // wrapping rise, i.e. in the PHI2-low half), free-running otherwise.
    // Each source is held cleared while the other is active, so entering
    // LOCKED restarts the rise count from zero.
    always_ff @(posedge i_c8m or posedge i_reset) begin
        if (i_reset) begin
            r_ref_cnt  <= '0;
            r_ref_pend <= 1'b0;
            r_free_cnt <= '0;
            r_ref_tick <= 1'b0;
        end else if (r_state == LOCKED) begin
            r_free_cnt <= '0;
            if (w_rise) begin
                if (r_ref_cnt == CNT_W'(REF_DIV - 1)) begin
                    r_ref_cnt  <= '0;
                    r_ref_pend <= 1'b1;
                end else begin
                    r_ref_cnt <= r_ref_cnt + CNT_W'(1);
                end
            end
            if (w_fall_pre && r_ref_pend) begin
                r_ref_tick <= 1'b1;
                r_ref_pend <= 1'b0;
            end else begin
                r_ref_tick <= 1'b0;
            end
        end else begin
            r_ref_cnt  <= '0;
            r_ref_pend <= 1'b0;
            if (r_free_cnt == FREE_W'(FREE_LAST)) begin
                r_free_cnt <= '0;
                r_ref_tick <= 1'b1;
            end else begin
                r_free_cnt <= r_free_cnt + FREE_W'(1);
                r_ref_tick <= 1'b0;
            end
        end
    end

    assign o_phi2s     = w_phi2s;
    assign o_phi2_rise = w_rise;
    assign o_phi2_fall = w_fall;
    assign o_phase     = r_phase;
    assign o_period    = r_period;
    assign o_locked    = r_locked;
    assign o_lost      = r_lost;
    assign o_ref_tick  = r_ref_tick;

endmodule

// File: tb/tb_phi2_phase_gen.sv
// Directed bench for phi2_phase_gen (default parameters, 8-cycle PHI2).
// Inputs change and outputs are sampled on the C8M falling edge; a monitor
// records strobe cycles #1 after each rising edge.
module tb_phi2_phase_gen;

    logic       c8m  = 1'b0;
    logic       rst  = 1'b1;
    logic       phi2 = 1'b0;
    logic       phi2s;
    logic       rise;
    logic       fall;
    logic [3:0] phase;
    logic [3:0] period;
    logic       locked;
    logic       lost;
    logic       ref_tick;
`ifdef PHI2_DUTY_CHECK_EN
    logic [3:0] hi_time;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    int cyc             = 0;
    int last_rise       = 0;
    int prev_rise       = 0;
    int n_lost          = 0;
    int lost_cyc        = 0;
    int locked_fall_cyc = 0;
    int n_tick          = 0;
    int last_tick       = 0;
    int prev_tick       = 0;
    int n_tick_off_fall = 0;
    int n_tick_hi       = 0;
    int base_lost       = 0;
    logic prev_locked   = 1'b0;

    always #5 c8m = ~c8m;

    phi2_phase_gen dut (
        .i_c8m       (c8m),
        .i_reset     (rst),
        .i_phi2      (phi2),
        .o_phi2s     (phi2s),
        .o_phi2_rise (rise),
        .o_phi2_fall (fall),
        .o_phase     (phase),
        .o_period    (period),
        .o_locked    (locked),
        .o_lost      (lost),
`ifdef PHI2_DUTY_CHECK_EN
        .o_hi_time   (hi_time),
`endif
        .o_ref_tick  (ref_tick)
    );

    always @(posedge c8m) begin
        #1;
        cyc++;
        if (rise) begin
            prev_rise = last_rise;
            last_rise = cyc;
        end
        if (lost) begin
            n_lost++;
            lost_cyc = cyc;
        end
        if (prev_locked && !locked) locked_fall_cyc = cyc;
        prev_locked = locked;
        if (ref_tick) begin
            n_tick++;
            prev_tick = last_tick;
            last_tick = cyc;
            if (!fall) n_tick_off_fall++;
            if (phi2s) n_tick_hi++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge c8m);
    endtask

    task automatic phi2_period(input int hi, input int lo);
        phi2 = 1'b1;
        nclk(hi);
        phi2 = 1'b0;
        nclk(lo);
    endtask

    task automatic run(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) phi2_period(hi, lo);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_phi2s"},  phi2s,    0);
        check({pfx, "_rise"},   rise,     0);
        check({pfx, "_fall"},   fall,     0);
        check({pfx, "_phase"},  phase,    0);
        check({pfx, "_period"}, period,   0);
        check({pfx, "_locked"}, locked,   0);
        check({pfx, "_lost"},   lost,     0);
        check({pfx, "_reftick"}, ref_tick, 0);
    endtask

    initial begin
        // Reset values
        nclk(3);
        check_all_zero("rst");
        rst = 1'b0;
        nclk(2);

        // First PHI2 rise: sync latency 2, strobe latency 3
        phi2 = 1'b1;
        nclk(1);
        check("sync_lat1_phi2s", phi2s, 0);
        nclk(1);
        check("sync_lat2_phi2s", phi2s, 1);
        check("rise_lat2", rise, 0);
        nclk(1);
        check("rise_lat3", rise, 1);
        nclk(1);
        phi2 = 1'b0;
        nclk(4);

        // Rises 2..4 are good but not yet enough; rise 5 locks
        run(3, 4, 4);
        check("no_lock_after_4_rises", locked, 0);
        check("period_8", period, 8);
        run(1, 4, 4);
        check("lock_after_5_rises", locked, 1);
        check("lost_clean", n_lost, 0);
        check("rise_interval", last_rise - prev_rise, 8);
        check("phase_after_fall", phase, 0);

        // Phase counts from the last fall strobe
        phi2 = 1'b1;
        nclk(2);
        check("phase_count", phase, 2);
        nclk(2);
        phi2 = 1'b0;
        nclk(4);

        // One 12-cycle period while locked
        run(2, 4, 4);
        base_lost = n_lost;
        phi2_period(4, 8);
        phi2_period(4, 4);
        check("lost_bad_period", n_lost - base_lost, 1);
        check("unlock_bad_period", locked, 0);
        check("locked_drop_after_lost", locked_fall_cyc - lost_cyc, 1);
        check("period_12", period, 12);
        run(3, 4, 4);
        check("no_relock_3_good", locked, 0);
        run(1, 4, 4);
        check("relock_4_good", locked, 1);
        check("lost_single", n_lost - base_lost, 1);

        // Locked refresh: ticks on the 7th and 14th rise's following fall
        n_tick = 0;
        n_tick_off_fall = 0;
        n_tick_hi = 0;
        run(14, 4, 4);
        check("locked_tick_count", n_tick, 2);
        check("locked_tick_on_fall", n_tick_off_fall, 0);
        check("locked_tick_not_high", n_tick_hi, 0);
        check("locked_tick_interval", last_tick - prev_tick, 56);
        check("still_locked", locked, 1);

        // PHI2 held low: timeout, unlock, free-running refresh
        base_lost = n_lost;
        n_tick = 0;
        phi2 = 1'b0;
        nclk(250);
        check("timeout_lost_once", n_lost - base_lost, 1);
        check("timeout_unlocked", locked, 0);
        check("phase_saturated", phase, 15);
        check("period_held", period, 8);
        check("free_tick_count", n_tick, 4);
        check("free_tick_interval", last_tick - prev_tick, 56);

        // Relock, then reset mid-LOCKED while PHI2 is high
        run(5, 4, 4);
        check("relock_after_timeout", locked, 1);
        run(1, 4, 4);
        phi2 = 1'b1;
        nclk(4);
        check("pre_reset_phi2s", phi2s, 1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        nclk(2);
        rst = 1'b0;
        nclk(4);
        phi2 = 1'b0;
        nclk(4);
        check("post_reset_unlocked", locked, 0);
        run(3, 4, 4);
        check("post_reset_4_rises", locked, 0);
        run(1, 4, 4);
        check("post_reset_5_rises", locked, 1);

`ifdef PHI2_DUTY_CHECK_EN
        check("hi_time_4", hi_time, 4);
        run(10, 1, 7);
        check("duty_narrow_unlocked", locked, 0);
        check("hi_time_1", hi_time, 1);
        run(6, 4, 4);
        check("duty_ok_locked", locked, 1);
        check("hi_time_4_again", hi_time, 4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
